// File: rtl/frame_sched_pkg.sv
// Shared opcodes, state codes and command layout for the frame scheduler.
package frame_sched_pkg;

  localparam int STATE_W = 3;

  localparam logic [3:0] OP_NOOP       = 4'd0;
  localparam logic [3:0] OP_START      = 4'd1;
  localparam logic [3:0] OP_STOP       = 4'd2;
  localparam logic [3:0] OP_SINGLE     = 4'd3;
  localparam logic [3:0] OP_SET_PERIOD = 4'd4;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ARMED   = 3'd1;
  localparam logic [STATE_W-1:0] ST_REQUEST = 3'd2;
  localparam logic [STATE_W-1:0] ST_RELEASE = 3'd3;
  localparam logic [STATE_W-1:0] ST_CLEAR   = 3'd4;

  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] arg;
  } cmd_t;

endpackage

// File: rtl/frame_scheduler_if.sv
// Host/USB-side signal bundle of the frame scheduler.
interface frame_scheduler_if;
  logic [15:0]                         command;
  logic                                send_done;
  logic                                start_sending;
  logic                                acquire_en;
  logic                                frame_clear;
  logic [15:0]                         frame_count;
  logic [frame_sched_pkg::STATE_W-1:0] state_out;
  logic                                timeout_err;

  modport master (
    output command, send_done,
    input  start_sending, acquire_en, frame_clear, frame_count, state_out, timeout_err
  );

  modport slave (
    input  command, send_done,
    output start_sending, acquire_en, frame_clear, frame_count, state_out, timeout_err
  );
endinterface

// File: rtl/frame_scheduler_period_timer.sv
// Loadable down-counter for the acquisition window; flags the last cycle (count == 1).
module period_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                     cnt_q <= '0;
    else if (load_i)               cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end

  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/frame_scheduler.sv
// Acquisition/transfer frame sequencer: IDLE -> ARMED -> REQUEST -> RELEASE -> CLEAR.
// Optional REQUEST watchdog enabled by defining FRAME_SCHED_TIMEOUT_EN.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int PERIOD_SHIFT   = 12,
  parameter int RELEASE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  frame_scheduler_if.slave  bus
);

  localparam int TMR_W = 12 + PERIOD_SHIFT;
  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [15:0]        cmd_prev_q;
  logic [11:0]        period_q, period_d;
  logic               cont_q, cont_d;
  logic [15:0]        count_q, count_d;
  logic [REL_W-1:0]   rel_q, rel_d;
  logic               acq_q, snd_q, clr_q;

  cmd_t       cmd;
  logic       new_cmd, is_stop, is_go, is_setp, go_accept;
  logic       tmr_load, tmr_expire, wd_hit;
  logic [TMR_W-1:0] tmr_val;

  assign cmd       = cmd_t'(bus.command);
  assign new_cmd   = (bus.command != cmd_prev_q);
  assign is_stop   = new_cmd && (cmd.op == OP_STOP);
  assign is_go     = new_cmd && (cmd.op == OP_START || cmd.op == OP_SINGLE);
  assign is_setp   = new_cmd && (cmd.op == OP_SET_PERIOD);
  assign go_accept = (state_q == ST_IDLE) && is_go;
  assign tmr_val   = TMR_W'(period_q) << PERIOD_SHIFT;

  period_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (state_q == ST_ARMED),
    .expire_o   (tmr_expire)
  );

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != ST_REQUEST) wd_q <= '0;
    else                                wd_q <= wd_q + WD_W'(1);
  end

  assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // send_done on the last allowed cycle still completes the frame
  always_ff @(posedge clk) begin
    if (reset)                                                   err_q <= 1'b0;
    else if (state_q == ST_REQUEST && !bus.send_done && wd_hit)  err_q <= 1'b1;
    else if (go_accept)                                          err_q <= 1'b0;
  end

  assign bus.timeout_err = err_q;
`else
  assign wd_hit          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    count_d  = count_q;
    rel_d    = rel_q;
    period_d = period_q;
    tmr_load = 1'b0;
    if (is_setp) period_d = (cmd.arg == 12'd0) ? 12'd1 : cmd.arg;
    if (is_stop) cont_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_go) begin
          cont_d   = (cmd.op == OP_START);
          tmr_load = 1'b1;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // STOP beats a same-cycle expiry
        if (is_stop)         state_d = ST_IDLE;
        else if (tmr_expire) state_d = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (bus.send_done) begin
          count_d = count_q + 16'd1;
          rel_d   = '0;
          state_d = ST_RELEASE;
        end else if (wd_hit) begin
          cont_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (rel_q == REL_W'(RELEASE_CYCLES - 1)) state_d = ST_CLEAR;
        else                                      rel_d   = rel_q + REL_W'(1);
      end
      ST_CLEAR: begin
        if (cont_d) begin
          tmr_load = 1'b1;
          state_d  = ST_ARMED;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_prev_q <= 16'd0;
      period_q   <= 12'd1;
      cont_q     <= 1'b0;
      count_q    <= 16'd0;
      rel_q      <= '0;
      acq_q      <= 1'b0;
      snd_q      <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_prev_q <= bus.command;
      period_q   <= period_d;
      cont_q     <= cont_d;
      count_q    <= count_d;
      rel_q      <= rel_d;
      // outputs decoded from next state so they line up with state_out
      acq_q      <= (state_d == ST_ARMED);
      snd_q      <= (state_d == ST_REQUEST);
      clr_q      <= (state_d == ST_CLEAR);
    end
  end

  assign bus.acquire_en    = acq_q;
  assign bus.start_sending = snd_q;
  assign bus.frame_clear   = clr_q;
  assign bus.frame_count   = count_q;
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed + randomized bench for frame_scheduler against a phase/countdown reference model.
module tb_frame_scheduler;
  localparam int PS = 0;
  localparam int RC = 4;
  localparam int TO = 20;
`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_scheduler_if bus();

  frame_scheduler #(
    .PERIOD_SHIFT  (PS),
    .RELEASE_CYCLES(RC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: phase 0..4 plus remaining-cycle countdowns
  int          m_state, m_period, m_left, m_rel, m_wd, m_count;
  bit          m_cont, m_err;
  logic [15:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [15:0] c;
    int op, arg;
    bit nw, stop, go;
    c = bus.command;
    op = int'(c[15:12]);
    arg = int'(c[11:0]);
    nw = (c != m_prev);
    stop = nw && op == 2;
    go = nw && (op == 1 || op == 3);
    if (reset) begin
      m_state = 0; m_prev = 16'd0; m_period = 1; m_cont = 0; m_count = 0;
      m_err = 0; m_left = 0; m_rel = 0; m_wd = 0;
    end else begin
      m_prev = c;
      if (stop) m_cont = 0;
      case (m_state)
        0: if (go) begin
             m_cont = (op == 1); m_err = 0; m_left = m_period << PS; m_state = 1;
           end
        1: if (stop) m_state = 0;
           else if (m_left == 1) begin m_state = 2; m_wd = 0; end
           else m_left--;
        2: if (bus.send_done) begin
             m_count = (m_count + 1) % 65536; m_rel = RC; m_state = 3;
           end else if (TO_EN && m_wd == TO - 1) begin
             m_err = 1; m_cont = 0; m_state = 0;
           end else m_wd++;
        3: begin m_rel--; if (m_rel == 0) m_state = 4; end
        default: if (m_cont) begin m_left = m_period << PS; m_state = 1; end
                 else m_state = 0;
      endcase
      if (nw && op == 4) m_period = (arg == 0) ? 1 : arg;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("state", 32'(bus.state_out), m_state);
    chk("acquire_en", 32'(bus.acquire_en), 32'(m_state == 1));
    chk("start_sending", 32'(bus.start_sending), 32'(m_state == 2));
    chk("frame_clear", 32'(bus.frame_clear), 32'(m_state == 4));
    chk("frame_count", 32'(bus.frame_count), m_count);
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
  endtask

  task automatic step(input logic [15:0] c, input logic s, input logic r);
    bus.command = c;
    bus.send_done = s;
    reset = r;
    tick();
  endtask

  initial begin
    int acq_n, lo_n, req_n, reent, target, prev, n;
    logic [15:0] c;
    logic sd;
    bus.command = 16'd0; bus.send_done = 1'b0; reset = 1'b1;
    m_prev = 16'd0; m_state = 0; m_period = 1; m_count = 0; m_cont = 0; m_err = 0;
    m_left = 0; m_rel = 0; m_wd = 0;

    step(16'h0000, 0, 1);
    step(16'h0000, 0, 1);
    chk("rst_count", 32'(bus.frame_count), 0);
    chk("rst_outs", 32'({bus.acquire_en, bus.start_sending, bus.frame_clear, bus.timeout_err}), 0);

    // single frame, period 10
    step(16'h400A, 0, 0);
    step(16'h3000, 0, 0);
    acq_n = 0;
    for (int i = 0; i < 40 && m_state != 2; i++) begin
      if (bus.acquire_en) acq_n++;
      step(16'h3000, 0, 0);
    end
    chk("single_acq_len", acq_n, 10);
    chk("single_req", 32'(bus.start_sending), 1);
    step(16'h3000, 0, 0);
    step(16'h3000, 1, 0);
    lo_n = 0;
    for (int i = 0; i < 20 && !bus.frame_clear; i++) begin
      if (!bus.start_sending) lo_n++;
      step(16'h3000, 0, 0);
    end
    chk("single_release_len", lo_n, 4);
    step(16'h3000, 0, 0);
    chk("single_idle", 32'(bus.state_out), 0);
    chk("single_count", 32'(bus.frame_count), 1);

    // repeated SINGLE without NOOP, then reserved opcode
    for (int i = 0; i < 5; i++) step(16'h3000, 0, 0);
    chk("repeat_single", 32'(bus.state_out), 0);
    step(16'h7123, 0, 0);
    chk("opcode7", 32'(bus.state_out), 0);

    // continuous, period 3, send_done on the 5th REQUEST cycle
    step(16'h0000, 0, 0);
    step(16'h4003, 0, 0);
    step(16'h1000, 0, 0);
    target = m_count + 3; req_n = 0; reent = 0;
    for (int i = 0; i < 400 && !(m_count == target && m_state == 1); i++) begin
      req_n = (m_state == 2) ? req_n + 1 : 0;
      prev = m_state;
      step(16'h1000, req_n == 5, 0);
      if (prev == 4 && m_state == 1) reent++;
    end
    chk("cont_count", 32'(bus.frame_count), target);
    chk("cont_reentry", reent, 3);
    step(16'h2000, 0, 0);
    chk("stop_armed", 32'(bus.state_out), 0);

    // STOP on the expiry cycle
    step(16'h1000, 0, 0);
    step(16'h1000, 0, 0);
    step(16'h1000, 0, 0);
    step(16'h2000, 0, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.start_sending) n++;
      step(16'h2000, 0, 0);
    end
    chk("stop_expiry_nosend", n, 0);
    chk("stop_expiry_state", 32'(bus.state_out), 0);

    // reset in REQUEST, then a stale send_done
    step(16'h0000, 0, 0);
    step(16'h3000, 0, 0);
    for (int i = 0; i < 40 && m_state != 2; i++) step(16'h3000, 0, 0);
    step(16'h0000, 0, 1);
    step(16'h0000, 1, 0);
    chk("rst_req_send", 32'(bus.start_sending), 0);
    chk("rst_req_count", 32'(bus.frame_count), 0);
    chk("rst_req_state", 32'(bus.state_out), 0);

`ifdef FRAME_SCHED_TIMEOUT_EN
    step(16'h1000, 0, 0);
    for (int i = 0; i < 40 && m_state != 2; i++) step(16'h1000, 0, 0);
    n = 0;
    for (int i = 0; i < 60 && bus.start_sending; i++) begin
      n++;
      step(16'h1000, 0, 0);
    end
    chk("wd_len", n, TO);
    chk("wd_err", 32'(bus.timeout_err), 1);
    step(16'h0000, 0, 0);
    step(16'h1000, 0, 0);
    chk("wd_err_clear", 32'(bus.timeout_err), 0);
    step(16'h2000, 0, 0);
`endif

    // randomized traffic
    c = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 6 == 0) begin
        case ($urandom % 7)
          0: c = 16'h0000;
          1: c = 16'h1000;
          2: c = 16'h2000;
          3: c = 16'h3000;
          4: c = {4'h4, 12'($urandom_range(0, 6))};
          5: c = {4'($urandom_range(5, 15)), 12'($urandom)};
          default: c = 16'h0000;
        endcase
      end
      sd = ($urandom % 5 == 0);
      step(c, sd, $urandom % 300 == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
